// File: rtl/dice_game_pkg.sv
// Shared constants, FSM encoding and prize encoding for the six-dice prize game.
package dice_game_pkg;

  localparam int NUM_DICE   = 6;
  localparam int FACE_W     = 3;
  localparam int NUM_FACES  = 6;
  localparam int NUM_PRIZES = 6;
  localparam int DICE_W     = NUM_DICE * FACE_W;
  localparam int IDX_W      = 3;
  localparam int BEST_W     = 3;
  localparam int EVAL_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EVAL    = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  // best_prize: 0 means no prize, otherwise the 1-based index of the winning prize line
  localparam logic [BEST_W-1:0] BEST_NONE  = 3'd0;
  localparam logic [BEST_W-1:0] BEST_FIRST = 3'd1;
  localparam logic [BEST_W-1:0] BEST_LAST  = 3'd6;

  function automatic logic face_legal(input logic [FACE_W-1:0] face);
    return face < 3'(NUM_FACES);
  endfunction

endpackage

// File: rtl/dice_round_ctrl_if.sv
// Roller, evaluator and result signals of dice_round_ctrl.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid
// never waits on ready, and data stays stable while valid is high and ready is low.
interface dice_round_ctrl_if;
  import dice_game_pkg::*;

  logic                  roll_valid;
  logic [FACE_W-1:0]     roll_face;
  logic                  roll_ready;
  logic [DICE_W-1:0]     dice_out;
  logic [NUM_PRIZES-1:0] prize_in;
  logic                  result_valid;
  logic                  result_ready;
  logic [NUM_PRIZES-1:0] prize_vec;
  logic [BEST_W-1:0]     best_prize;

  // Environment side: roller, evaluator and result consumer
  modport master (
    output roll_valid, roll_face, prize_in, result_ready,
    input  roll_ready, dice_out, result_valid, prize_vec, best_prize
  );

  // Round controller side
  modport slave (
    input  roll_valid, roll_face, prize_in, result_ready,
    output roll_ready, dice_out, result_valid, prize_vec, best_prize
  );

endinterface

// File: rtl/prize_prio_enc.sv
// Priority encoder: lowest-numbered asserted prize line wins; empty vector gives BEST_NONE.
module prize_prio_enc
  import dice_game_pkg::*;
(
  input  logic [NUM_PRIZES-1:0] prize,
  output logic [BEST_W-1:0]     best
);

  always_comb begin
    best = BEST_NONE;
    // Walk from P6 down so the lowest asserted line is written last
    for (int k = NUM_PRIZES - 1; k >= 0; k--) begin
      if (prize[k]) best = BEST_W'(k + 1);
    end
  end

endmodule

// File: rtl/dice_round_ctrl.sv
// Round sequencer for the six-dice prize game: collect dice, settle evaluator, report best prize.
// Optional statistics counters are enabled by defining DICE_STATS_EN.
module dice_round_ctrl
  import dice_game_pkg::*;
#(
  parameter int EVAL_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  dice_round_ctrl_if.slave bus,
  output logic   busy,
  output state_t state_dbg
`ifdef DICE_STATS_EN
  ,
  output logic [CNT_W-1:0]            rounds_done,
  output logic [NUM_PRIZES*CNT_W-1:0] win_cnt
`endif
);

  // Out-of-range settings fall back to a single settle cycle
  localparam bit PARAMS_OK = (EVAL_CYCLES >= 1) && (EVAL_CYCLES <= 15) && (CNT_W >= 1);
  localparam logic [EVAL_CNT_W-1:0] EVAL_LOAD = PARAMS_OK ? EVAL_CNT_W'(EVAL_CYCLES) : 4'd1;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [EVAL_CNT_W-1:0] cnt;
  logic [BEST_W-1:0]     best_next;
  logic                  die_accept;

  prize_prio_enc u_prio (
    .prize (bus.prize_in),
    .best  (best_next)
  );

  assign die_accept = bus.roll_valid && bus.roll_ready && face_legal(bus.roll_face);
  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      idx              <= '0;
      cnt              <= '0;
      bus.dice_out     <= '0;
      bus.prize_vec    <= '0;
      bus.best_prize   <= BEST_NONE;
      bus.result_valid <= 1'b0;
      bus.roll_ready   <= 1'b0;
    end else if (abort && (state != ST_IDLE)) begin
      // prize_vec, best_prize and dice_out deliberately keep their last values
      state            <= ST_IDLE;
      bus.result_valid <= 1'b0;
      bus.roll_ready   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state          <= ST_COLLECT;
            idx            <= '0;
            bus.dice_out   <= '0;
            bus.roll_ready <= 1'b1;
          end
        end

        ST_COLLECT: begin
          if (die_accept) begin
            for (int k = 0; k < NUM_DICE; k++) begin
              if (idx == IDX_W'(k)) bus.dice_out[k*FACE_W +: FACE_W] <= bus.roll_face;
            end
            if (idx == IDX_W'(NUM_DICE - 1)) begin
              state          <= ST_EVAL;
              bus.roll_ready <= 1'b0;
              cnt            <= EVAL_LOAD;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        ST_EVAL: begin
          if (cnt == '0) begin
            state            <= ST_REPORT;
            bus.prize_vec    <= bus.prize_in;
            bus.best_prize   <= best_next;
            bus.result_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_REPORT: begin
          if (bus.result_ready) begin
            state            <= ST_IDLE;
            bus.result_valid <= 1'b0;
          end
        end

        default: begin
          state            <= ST_IDLE;
          bus.result_valid <= 1'b0;
          bus.roll_ready   <= 1'b0;
        end
      endcase
    end
  end

`ifdef DICE_STATS_EN
  logic result_taken;

  // Abort overrides the result handshake, so an aborted round is never counted
  assign result_taken = (state == ST_REPORT) && bus.result_valid && bus.result_ready && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      rounds_done <= '0;
      win_cnt     <= '0;
    end else if (result_taken) begin
      if (rounds_done != '1) rounds_done <= rounds_done + 1'b1;
      for (int k = 0; k < NUM_PRIZES; k++) begin
        if (bus.prize_vec[k] && (win_cnt[k*CNT_W +: CNT_W] != '1)) begin
          win_cnt[k*CNT_W +: CNT_W] <= win_cnt[k*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dice_round_ctrl.sv
// Directed bench for dice_round_ctrl: driver tasks issue rounds, a negedge monitor scores results.
`timescale 1ns/1ps
module tb_dice_round_ctrl;
  import dice_game_pkg::*;

  localparam int EVAL_CYCLES = 1;
  localparam int CNT_W       = 16;
  localparam int EXP_W       = DICE_W + NUM_PRIZES + BEST_W;

  logic   clk = 1'b0;
  logic   rst;
  logic   start;
  logic   abort;
  logic   busy;
  state_t state_dbg;
`ifdef DICE_STATS_EN
  logic [CNT_W-1:0]            rounds_done;
  logic [NUM_PRIZES*CNT_W-1:0] win_cnt;
`endif

  dice_round_ctrl_if bus ();

  dice_round_ctrl #(.EVAL_CYCLES(EVAL_CYCLES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
`ifdef DICE_STATS_EN
    ,
    .rounds_done (rounds_done),
    .win_cnt     (win_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.result_valid && bus.result_ready) begin : mon
      logic [EXP_W-1:0] e;
      check("result_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result", 32'({bus.dice_out, bus.prize_vec, bus.best_prize}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic start_round();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_die(input logic [FACE_W-1:0] face);
    int n;
    n = 0;
    bus.roll_valid = 1'b1;
    bus.roll_face  = face;
    while (!bus.roll_ready && n < 20) begin
      tick();
      n++;
    end
    check("roll_ready", 32'(bus.roll_ready), 32'd1);
    tick();
    bus.roll_valid = 1'b0;
  endtask

  task automatic send_illegal(input logic [FACE_W-1:0] face);
    bus.roll_valid = 1'b1;
    bus.roll_face  = face;
    tick();
    bus.roll_valid = 1'b0;
    check("illegal_ready", 32'(bus.roll_ready), 32'd1);
    check("illegal_state", 32'(state_dbg), 32'(ST_COLLECT));
  endtask

  // faces packed as {D6..D1}; D1 goes out first
  task automatic send_six(input logic [DICE_W-1:0] faces);
    for (int k = 0; k < NUM_DICE; k++) send_die(faces[k*FACE_W +: FACE_W]);
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!bus.result_valid && n < 40) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(EVAL_CYCLES + 1));
  endtask

  task automatic run_round(input logic [DICE_W-1:0] faces, input logic [NUM_PRIZES-1:0] prize,
                           input logic [BEST_W-1:0] best);
    exp_q.push_back({faces, prize, best});
    bus.prize_in     = prize;
    bus.result_ready = 1'b1;
    start_round();
    send_six(faces);
    wait_result();
    tick();
    check("round_end_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    check({tag, "_dice"}, 32'(bus.dice_out), 32'd0);
    check({tag, "_prize_vec"}, 32'(bus.prize_vec), 32'd0);
    check({tag, "_best"}, 32'(bus.best_prize), 32'd0);
    check({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_roll_ready"}, 32'(bus.roll_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    bus.roll_valid = 1'b0; bus.roll_face = '0; bus.prize_in = '0; bus.result_ready = 1'b0;
    do_reset();
    check_reset_values("reset");

    // 1: basic round, prize P1
    run_round(18'o103333, 6'b000001, 3'd1);

    // 2: illegal code between dice 2 and 3 is dropped, no prize
    exp_q.push_back({18'o543210, 6'b000000, 3'd0});
    bus.prize_in = 6'b000000;
    start_round();
    send_die(3'd0);
    send_die(3'd1);
    send_illegal(3'd7);
    check("illegal_dice_hold", 32'(bus.dice_out), 32'(18'o000010));
    send_die(3'd2);
    send_die(3'd3);
    send_die(3'd4);
    send_die(3'd5);
    wait_result();
    tick();

    // 3: consumer stalls 10 cycles, outputs must hold
    exp_q.push_back({18'o555555, 6'b101100, 3'd3});
    bus.prize_in     = 6'b101100;
    bus.result_ready = 1'b0;
    start_round();
    send_six(18'o555555);
    wait_result();
    bus.prize_in = 6'b000000;
    repeat (10) begin
      check("hold_valid", 32'(bus.result_valid), 32'd1);
      check("hold_data", 32'({bus.dice_out, bus.prize_vec, bus.best_prize}),
            32'({18'o555555, 6'b101100, 3'd3}));
      tick();
    end
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("stall_drop_valid", 32'(bus.result_valid), 32'd0);
    check("stall_idle", 32'(state_dbg), 32'(ST_IDLE));

    // 4: abort after three dice, with a legal die offered on the same edge
    bus.result_ready = 1'b1;
    start_round();
    send_die(3'd1);
    send_die(3'd2);
    send_die(3'd3);
    abort = 1'b1;
    bus.roll_valid = 1'b1;
    bus.roll_face  = 3'd5;
    tick();
    abort = 1'b0;
    bus.roll_valid = 1'b0;
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    check("abort_roll_ready", 32'(bus.roll_ready), 32'd0);
    check("abort_result_valid", 32'(bus.result_valid), 32'd0);
    check("abort_dice_kept", 32'(bus.dice_out), 32'(18'o000321));
    check("abort_prize_kept", 32'(bus.prize_vec), 32'(6'b101100));
    check("abort_best_kept", 32'(bus.best_prize), 32'd3);
    repeat (3) tick();
    check("abort_no_result", 32'(bus.result_valid), 32'd0);
    start_round();
    check("restart_dice_clear", 32'(bus.dice_out), 32'd0);
    check("restart_state", 32'(state_dbg), 32'(ST_COLLECT));
    send_die(3'd4);
    check("restart_idx0", 32'(bus.dice_out), 32'(18'o000004));
    exp_q.push_back({18'o000004, 6'b010000, 3'd5});
    bus.prize_in = 6'b010000;
    repeat (5) send_die(3'd0);
    wait_result();
    tick();

    // 5a: reset during EVAL
    bus.prize_in = 6'b000001;
    start_round();
    send_six(18'o012345);
    check("eval_state", 32'(state_dbg), 32'(ST_EVAL));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("midrst");

    // 5b: start during REPORT is ignored
    exp_q.push_back({18'o222222, 6'b000010, 3'd2});
    bus.prize_in     = 6'b000010;
    bus.result_ready = 1'b0;
    start_round();
    send_six(18'o222222);
    wait_result();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("report_start_state", 32'(state_dbg), 32'(ST_REPORT));
    check("report_start_valid", 32'(bus.result_valid), 32'd1);
    check("report_start_ready", 32'(bus.roll_ready), 32'd0);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("report_exit_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    check("report_no_queue", 32'(busy), 32'd0);

`ifdef DICE_STATS_EN
    // 6: statistics over three completed rounds and one aborted
    do_reset();
    check("stats_reset", 32'(rounds_done), 32'd0);
    run_round(18'o111111, 6'b000001, 3'd1);
    run_round(18'o000000, 6'b000000, 3'd0);
    run_round(18'o333333, 6'b010000, 3'd5);
    bus.prize_in = 6'b111111;
    start_round();
    send_die(3'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("stats_rounds", 32'(rounds_done), 32'd3);
    check("stats_win0", 32'(win_cnt[0*CNT_W +: CNT_W]), 32'd1);
    check("stats_win1", 32'(win_cnt[1*CNT_W +: CNT_W]), 32'd0);
    check("stats_win4", 32'(win_cnt[4*CNT_W +: CNT_W]), 32'd1);
    check("stats_win5", 32'(win_cnt[5*CNT_W +: CNT_W]), 32'd0);
`endif

    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
